// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin grant arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [IDX_W-1:0] arb_idx_t;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin winner pick: first set request at or above ptr, wrapping.
module rr_pick8
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  arb_idx_t         ptr,
    output arb_idx_t         idx,
    output logic             found
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    arb_idx_t           off;

    // Rotating right by ptr puts the highest-priority requester at bit 0.
    assign dbl = {req, req};
    assign rot = N_REQ'(dbl >> ptr);

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = arb_idx_t'(i);
                found = 1'b1;
            end
        end
    end

    assign idx = off + ptr;

endmodule

// File: rtl/rr_arbiter_8to3.sv
// Registered round-robin arbiter: holds a binary grant index until ack or timeout,
// then hands priority to the requester after the one just served.
//
//   state | meaning
//   IDLE  | no grant outstanding, waiting for any request
//   GRANT | grant_idx held; released by ack or hold-counter expiry
module rr_arbiter_8to3
    import arb_pkg::*;
#(
    parameter int N_REQ   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    output arb_idx_t         grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

    arb_state_t       state;
    arb_idx_t         ptr;
    logic [CNT_W-1:0] cnt;
    arb_idx_t         pick_ptr;
    arb_idx_t         pick_idx;
    logic             pick_found;
    logic             expire;

    // While granting, the picker already looks one past the current grant so a
    // release can re-arbitrate in the same edge.
    assign pick_ptr = (state == GRANT) ? grant_idx + 3'd1 : ptr;
    assign expire   = (TIMEOUT != 0) && (cnt == CNT_LAST);

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        cnt         <= '0;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack || expire) begin
                        ptr     <= pick_ptr;
                        cnt     <= '0;
                        timeout <= ~ack;
                        if (pick_found) begin
                            grant_idx <= pick_idx;
                        end else begin
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// Bench for rr_arbiter_8to3: directed test-plan steps, then random traffic against a
// scan-based reference model of the round-robin rules.
module tb_rr_arbiter_8to3;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    // reference model
    int m_ptr, m_idx, m_valid, m_cnt, m_to;

    rr_arbiter_8to3 #(.N_REQ(8), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .ack         (ack),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    function automatic int winner(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_idx = 0; m_valid = 0; m_cnt = 0; m_to = 0;
    endtask

    task automatic model_edge();
        int w;
        m_to = 0;
        if (m_valid == 0) begin
            w = winner(req, m_ptr);
            if (w >= 0) begin
                m_idx = w; m_valid = 1; m_cnt = 0;
            end
        end else if (ack || m_cnt == TO - 1) begin
            m_to  = ack ? 0 : 1;
            m_ptr = (m_idx + 1) % 8;
            m_cnt = 0;
            w = winner(req, m_ptr);
            if (w >= 0) m_idx = w;
            else m_valid = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_idx", int'(grant_idx), m_idx);
        chk("model_valid", int'(grant_valid), m_valid);
        chk("model_timeout", int'(timeout), m_to);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = 8'h00; ack = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_valid", int'(grant_valid), 0);
        chk("rst_timeout", int'(timeout), 0);

        // reset mid-grant
        req = 8'h20;
        step();
        chk("pre_rst_idx", int'(grant_idx), 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_idx", int'(grant_idx), 0);
        chk("midrst_valid", int'(grant_valid), 0);
        req = 8'h01;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("post_rst_idx", int'(grant_idx), 0);
        chk("post_rst_valid", int'(grant_valid), 1);

        // basic rotation from ptr 0
        do_reset();
        req = 8'b1000_0100;
        step();
        chk("rot_a", int'(grant_idx), 2);
        ack = 1'b1;
        step();
        chk("rot_b", int'(grant_idx), 7);
        step();
        chk("rot_wrap", int'(grant_idx), 2);

        // sticky grant: take index 3 then drop its request
        req = 8'h08;
        step();
        chk("sticky_grant", int'(grant_idx), 3);
        ack = 1'b0; req = 8'h00;
        step();
        step();
        chk("sticky_idx", int'(grant_idx), 3);
        chk("sticky_valid", int'(grant_valid), 1);

        // drain to idle, then spurious ack must not move ptr (still 4)
        ack = 1'b1;
        step();
        chk("drain_valid", int'(grant_valid), 0);
        step();
        chk("spur_valid", int'(grant_valid), 0);
        chk("spur_idx", int'(grant_idx), 3);
        ack = 1'b0; req = 8'hFF;
        step();
        chk("spur_ptr_kept", int'(grant_idx), 4);

        // timeout: sole requester 0, never acked
        ack = 1'b1; req = 8'h00;
        step();
        ack = 1'b0; req = 8'h01;
        step();
        chk("to_grant", int'(grant_idx), 0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("to_hold", int'(timeout), 0);
        end
        step();
        chk("to_pulse", int'(timeout), 1);
        chk("to_regrant", int'(grant_idx), 0);
        chk("to_regrant_v", int'(grant_valid), 1);
        step();
        chk("to_single", int'(timeout), 0);
        step();
        step();
        ack = 1'b1;
        step();
        chk("to_ack_wins", int'(timeout), 0);
        ack = 1'b0;

        // all requesting with ack held: 0..7,0
        do_reset();
        req = 8'hFF; ack = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("all_seq", int'(grant_idx), k % 8);
            chk("all_valid", int'(grant_valid), 1);
        end

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            if (n % 150 == 149) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
